// File: rtl/stream_monitor.sv
// Passive valid/ready protocol monitor: counts handshakes, flags stalls, data
// instability and valid drops, and queues those events in a small FWFT FIFO.
module stream_monitor #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mon_valid,
    input  logic              mon_ready,
    input  logic [DATA_W-1:0] mon_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_code,
    output logic [CNT_W-1:0]  evt_cycles,
    output logic [DATA_W-1:0] evt_data,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EVT_XFER_OK       = 2'd0,
        EVT_STABILITY_ERR = 2'd1,
        EVT_VALID_DROP    = 2'd2,
        EVT_TIMEOUT       = 2'd3
    } evt_code_t;

    typedef struct packed {
        evt_code_t         code;
        logic [CNT_W-1:0]  cycles;
        logic [DATA_W-1:0] data;
    } evt_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_nxt;
    logic [DATA_W-1:0]   latched, latched_nxt;
    logic                stab_flag, stab_flag_nxt;
    logic                handshake;
    logic                push_req;
    evt_t                push_evt;

    assign handshake = mon_valid & mon_ready;

    // ------------------------------------------------------------------
    // Protocol tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            latched    <= '0;
            stab_flag  <= 1'b0;
            xfer_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            latched   <= latched_nxt;
            stab_flag <= stab_flag_nxt;
            if (handshake) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        logic to_idle;
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        latched_nxt     = latched;
        stab_flag_nxt   = stab_flag;
        push_req        = 1'b0;
        push_evt.code   = EVT_XFER_OK;
        push_evt.cycles = '0;
        push_evt.data   = mon_data;
        to_idle         = 1'b0;

        unique case (state)
            IDLE: begin
                if (handshake) begin
                    push_req = 1'b1;
                end else if (mon_valid) begin
                    latched_nxt = mon_data;
                    wait_nxt    = CNT_W'(1);
                    state_nxt   = PEND;
                end
            end

            PEND, STALL: begin
                wait_nxt        = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
                push_evt.cycles = wait_cnt;
                if (!mon_valid) begin
                    push_req      = 1'b1;
                    push_evt.code = EVT_VALID_DROP;
                    to_idle       = 1'b1;
                end else if (mon_data != latched && !stab_flag) begin
                    // A simultaneous handshake still completes, but the error
                    // takes the single event slot for this cycle.
                    push_req      = 1'b1;
                    push_evt.code = EVT_STABILITY_ERR;
                    stab_flag_nxt = 1'b1;
                    to_idle       = handshake;
                end else if (handshake) begin
                    push_req      = 1'b1;
                    push_evt.code = EVT_XFER_OK;
                    to_idle       = 1'b1;
                end else if (state == PEND && wait_cnt == TIMEOUT_C) begin
                    push_req      = 1'b1;
                    push_evt.code = EVT_TIMEOUT;
                    state_nxt     = STALL;
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (to_idle) begin
            state_nxt     = IDLE;
            wait_nxt      = '0;
            latched_nxt   = '0;
            stab_flag_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through through a registered head)
    // ------------------------------------------------------------------
    evt_t             mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             fifo_empty, fifo_full;
    logic             pop, push_ok, push_drop;
    evt_t             head_q, head_nxt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = evt_ready & ~fifo_empty;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;
    assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push_ok};
    assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};

    // NOTE: storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the RAM would only cost area.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_evt;
        end
    end

    // Next head: the entry being written this cycle when it lands on the new
    // read slot (empty FIFO, or last entry popped), otherwise stored data.
    always_comb begin
        head_nxt = head_q;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (push_ok && wr_ptr[PTR_W-1:0] == rd_ptr_nxt[PTR_W-1:0]) begin
                head_nxt = push_evt;
            end else begin
                head_nxt = mem[rd_ptr_nxt[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_q   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            head_q <= head_nxt;
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign evt_valid  = ~fifo_empty;
    assign evt_code   = head_q.code;
    assign evt_cycles = head_q.cycles;
    assign evt_data   = head_q.data;

endmodule

// File: doc/stream_monitor.md
STREAM_MONITOR -- requirements
Module: stream_monitor

Interface
REQ-001 The parameter DATA_W SHALL default to 8 and set the width of the watched data bus.
REQ-002 The parameter CNT_W SHALL default to 16 and set the width of the cycle and transfer counters.
REQ-003 The parameter TIMEOUT SHALL default to 16 and give the number of stall cycles that raises a timeout event; the legal range is 1 to 2^CNT_W-1.
REQ-004 The parameter DEPTH SHALL default to 4 and give the event FIFO depth; it must be a power of 2 and at least 2.
REQ-005 clk  input  1  Single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  Reset; asynchronous and active-low.
REQ-007 mon_valid  input  1  Valid of the watched stream.
REQ-008 mon_ready  input  1  Ready of the watched stream.
REQ-009 mon_data  input  DATA_W  Data of the watched stream.
REQ-010 evt_valid  output  1  The event FIFO is not empty.
REQ-011 evt_ready  input  1  The consumer pops the head event.
REQ-012 evt_code  output  2  Head event code: 0 XFER_OK, 1 STABILITY_ERR, 2 VALID_DROP, 3 TIMEOUT.
REQ-013 evt_cycles  output  CNT_W  Head event wait-cycle count.
REQ-014 evt_data  output  DATA_W  Head event data (mon_data at the event cycle).
REQ-015 xfer_count  output  CNT_W  Number of completed handshakes; wraps around modulo 2^CNT_W.
REQ-016 overflow  output  1  Sticky flag: an event was lost because the FIFO was full.

Function
REQ-017 A handshake SHALL be any cycle in which mon_valid and mon_ready are both 1; each handshake increments xfer_count by 1.
REQ-018 The block SHALL have three states:
- IDLE: no transfer pending.
- PEND: valid is held without ready.
- STALL: pending, and the timeout has already been reported.
REQ-019 In IDLE:
- Handshake: push XFER_OK with cycles=0; stay in IDLE.
- mon_valid=1 and mon_ready=0: latch mon_data, set wait=1, go to PEND.
- Otherwise: no action.
REQ-020 wait SHALL increment by 1 every cycle spent in PEND or STALL, and SHALL saturate at 2^CNT_W-1.
REQ-021 In PEND or STALL, the first matching rule below SHALL apply each cycle (priority order):
- (a) mon_valid=0: push VALID_DROP with cycles=wait; go to IDLE.
- (b) mon_data differs from the latched value and this pending period has not yet flagged an error: push STABILITY_ERR with cycles=wait; set the flag. A handshake in the same cycle still counts and returns the block to IDLE, but no XFER_OK is pushed.
- (c) Handshake: push XFER_OK with cycles=wait; go to IDLE.
- (d) In PEND with wait=TIMEOUT: push TIMEOUT with cycles=wait; go to STALL.
REQ-022 At most one event SHALL be pushed per cycle.
REQ-023 The stability flag and the latched data SHALL clear on every entry to IDLE.
REQ-024 The monitor SHALL NOT apply back-pressure; mon_ready is observe-only.
REQ-025 Push latency: an event detected in cycle t SHALL be visible on evt_* after the rising edge ending cycle t.
REQ-026 evt_* SHALL present the FIFO head in first-word-fall-through style; the head pops when evt_valid=1 and evt_ready=1.
REQ-027 When the FIFO is full and no pop occurs, a push SHALL be dropped and overflow set to 1; overflow holds until reset.
REQ-028 When the FIFO is full, a push and a pop in the same cycle SHALL both be accepted, with no overflow.
REQ-029 When the FIFO is empty, evt_ready SHALL be ignored, and evt_code, evt_cycles and evt_data SHALL hold their last values.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with an extra pointer bit.

Reset
REQ-031 While rst_n=0, the block SHALL hold: state=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_cycles=0, evt_data=0, xfer_count=0, overflow=0, wait=0, stability flag=0.
REQ-032 Reset asserted mid-pending or with a non-empty FIFO SHALL discard all pending and queued events, with no partial event emitted.
REQ-033 After rst_n deasserts, the first rising edge SHALL operate as IDLE.

Verification
REQ-034 Handshake in IDLE: mon_valid=mon_ready=1 with data 0xA5 for one cycle, evt_ready=1 -> one event {XFER_OK, 0, 0xA5} the next cycle; xfer_count=1.
REQ-035 Stall then transfer: valid with data 0x3C, ready=0 for 3 cycles, then ready=1 -> {XFER_OK, 3, 0x3C}; no other events.
REQ-036 Timeout: TIMEOUT=4, valid held with ready=0 for 10 cycles, then handshake -> {TIMEOUT, 4} followed by {XFER_OK, 10}; only one TIMEOUT event.
REQ-037 Stability and drop: data changes 0x11->0x22 at wait=2, changes again at wait=3, then valid drops at wait=5 -> {STABILITY_ERR, 2, 0x22} then {VALID_DROP, 5}.
REQ-038 Overflow: DEPTH=4, evt_ready=0, 6 back-to-back IDLE handshakes -> evt_valid=1 with 4 entries queued and overflow=1; then 1 handshake with evt_ready=1 in the same cycle -> push accepted and occupancy stays 4.
REQ-039 Reset mid-pending: rst_n low for 1 cycle at wait=3 with 2 queued events -> all outputs 0 and the FIFO empty; the next IDLE handshake reports cycles=0.
